// File: rtl/prescaled_mod_counter.sv
// prescaled_mod_counter
//   Up/down modulo counter whose count advances once every PRESCALE
//   qualified inc cycles. Counts 0..MODULUS-1 with wrap in both directions,
//   a one-cycle terminal-count pulse on each wrap and a sticky wrap flag.
//
// Ports
//   clk       sole clock, rising edge
//   clr       asynchronous reset, active low
//   sclr      synchronous clear (highest priority)
//   load      synchronous load of load_val, saturated to MODULUS-1
//   inc       count enable, advances the prescaler
//   dir       1 = up, 0 = down
//   load_val  load value
//   ovf_clr   clears sticky ovf (a wrap on the same edge wins)
//   count     current count (registered)
//   tc        terminal-count pulse (registered)
//   ovf       sticky wrap flag (registered)
module prescaled_mod_counter #(
  parameter int     WIDTH    = 30,
  parameter longint MODULUS  = 64'sd1 << 30,
  parameter int     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sclr,
  input  logic             inc,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam int PW = $clog2(PRESCALE) + 1;

  // Constants sliced from wide intermediates so MODULUS = 2**WIDTH gives an
  // all-ones MAXV and the +1/-1 wrap lands exactly on natural overflow.
  localparam logic [63:0]      MAX64    = 64'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAXV     = MAX64[WIDTH-1:0];
  localparam logic [31:0]      PL32     = 32'(PRESCALE - 1);
  localparam logic [PW-1:0]    PRE_LAST = PL32[PW-1:0];

  generate
    if (WIDTH < 1 || WIDTH > 62 || MODULUS < 2 ||
        MODULUS > (64'sd1 << WIDTH) || PRESCALE < 1) begin : g_bad_params
      $fatal(1, "prescaled_mod_counter: illegal WIDTH/MODULUS/PRESCALE");
    end
  endgenerate

  logic [WIDTH-1:0] r_count;
  logic [PW-1:0]    r_pre;
  logic             r_tc;
  logic             r_ovf;

  logic             w_step;
  logic             w_at_end;
  logic             w_wrap;
  logic [WIDTH-1:0] w_cnt_step;
  logic [WIDTH-1:0] w_load_sat;

  always_comb begin
    // A step only happens when inc is the action that wins this edge.
    w_step     = ~sclr & ~load & inc & (r_pre == PRE_LAST);
    w_at_end   = dir ? (r_count == MAXV) : (r_count == '0);
    w_wrap     = w_step & w_at_end;
    w_cnt_step = r_count;
    if (dir) w_cnt_step = w_at_end ? '0   : r_count + WIDTH'(1);
    else     w_cnt_step = w_at_end ? MAXV : r_count - WIDTH'(1);
    w_load_sat = (load_val > MAXV) ? MAXV : load_val;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_count <= '0;
      r_pre   <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (sclr) begin
        r_count <= '0;
        r_pre   <= '0;
      end else if (load) begin
        r_count <= w_load_sat;
        r_pre   <= '0;
      end else if (inc) begin
        if (w_step) begin
          r_pre   <= '0;
          r_count <= w_cnt_step;
          r_tc    <= w_wrap;
        end else begin
          r_pre <= r_pre + PW'(1);
        end
      end
      // Sticky flag: a wrap beats a simultaneous clear.
      if (w_wrap)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign ovf   = r_ovf;

endmodule

// File: doc/prescaled_mod_counter.md
PRESCALED_MOD_COUNTER -- requirements
Module: prescaled_mod_counter

Interface
REQ-001 Parameter WIDTH, default 30, count register width in bits.
REQ-002 Parameter MODULUS, default 2**30, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH.
REQ-003 Parameter PRESCALE, default 1, number of qualified inc cycles per count step; legal range PRESCALE >= 1.
REQ-004 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 Port clr  input  1  reset, asynchronous, active-low; assertion (0) SHALL reset all state immediately, independent of clk.
REQ-006 Port sclr  input  1  synchronous clear, active-high.
REQ-007 Port inc  input  1  count enable; each high cycle advances the prescaler.
REQ-008 Port dir  input  1  direction; 1 = up, 0 = down.
REQ-009 Port load  input  1  synchronous load of load_val, active-high.
REQ-010 Port load_val  input  WIDTH  value for load.
REQ-011 Port ovf_clr  input  1  clears sticky ovf, active-high.
REQ-012 Port count  output  WIDTH  current count, registered.
REQ-013 Port tc  output  1  terminal-count pulse, registered.
REQ-014 Port ovf  output  1  sticky wrap flag, registered.

Function
REQ-015 Internal prescaler pre SHALL be $clog2(PRESCALE)+1 bits wide and range 0..PRESCALE-1.
REQ-016 Per-edge priority SHALL be: sclr > load > inc; lower-priority actions are ignored that cycle.
REQ-017 sclr=1: count<=0, pre<=0, tc<=0; ovf unchanged except by REQ-024.
REQ-018 load=1 (sclr=0): count<=min(load_val, MODULUS-1), pre<=0, tc<=0.
REQ-019 inc=1 with pre<PRESCALE-1: pre<=pre+1, count unchanged, tc<=0.
REQ-020 inc=1 with pre==PRESCALE-1: pre<=0 and a step occurs; with PRESCALE=1 every inc cycle is a step.
REQ-021 Up step: count<=count+1, except count==MODULUS-1 -> count<=0 (wrap).
REQ-022 Down step: count<=count-1, except count==0 -> count<=MODULUS-1 (wrap).
REQ-023 tc SHALL be 1 for exactly the one cycle following a wrapping step edge, else 0; inc=0 holds count and pre and drives tc<=0.
REQ-024 ovf SHALL set on any wrapping step; ovf_clr=1 clears it; simultaneous wrap and ovf_clr SHALL leave ovf=1.
REQ-025 dir changes SHALL take effect on the next step without resetting pre.
REQ-026 Step latency: count reflects a step on the same rising edge on which the qualifying inc is sampled (one-cycle register latency, no combinational path from inputs to outputs).
REQ-027 Arithmetic SHALL be WIDTH bits unsigned; intermediate +1/-1 SHALL NOT truncate at MODULUS=2**WIDTH (wrap is natural overflow in that case).
REQ-028 Illegal parameters SHALL fail elaboration via an assertion.

Reset
REQ-029 While clr=0: count=0, pre=0, tc=0, ovf=0, regardless of clk and all other inputs.
REQ-030 clr deasserting mid-prescale SHALL restart from pre=0; first step occurs on the PRESCALE-th inc cycle after release.
REQ-031 clr assertion mid-operation SHALL discard any pending step in the same cycle.

Verification (WIDTH=4, MODULUS=10, PRESCALE=3 unless stated)
REQ-032 Up wrap: dir=1, inc=1 for 30 cycles from reset -> count steps every 3rd edge 0..9 then 0; tc=1 one cycle after the 9->0 edge; ovf=1 thereafter.
REQ-033 Down wrap: load load_val=0, then dir=0, inc=1 for 3 cycles -> count=9, tc pulse, ovf=1; ovf_clr=1 on the same edge as a second wrap -> ovf remains 1.
REQ-034 Priority: sclr=1, load=1, load_val=5, inc=1 on one edge -> count=0, pre=0; next edge load=1 only -> count=5; load_val=15 -> count=9.
REQ-035 Reset mid-count: count=7, pre=2, clr pulsed low between edges -> count=0, ovf=0 immediately; after release 3 inc cycles required for count=1.
REQ-036 Full-width: WIDTH=4, MODULUS=16, PRESCALE=1, dir=1, inc=1 -> 15->0 wrap with tc pulse, no X/truncation; inc=0 gaps hold count and pre.
